serial_sub_ctrl: RTL

Bit-serial multi-bit subtractor controller. It computes a WIDTH-bit difference, a − b − bin, by sequencing a single one-bit full-subtractor cell LSB-first over WIDTH cycles. It owns the operand shift registers, the borrow flip-flop and the bit counter. It presents a start/busy/done handshake to the surrounding datapath, trading latency for area versus a ripple array of full subtractors.

---
 rtl/serial_sub_ctrl_pkg.sv | 19 +
 rtl/serial_sub_ctrl_if.sv | 29 ++
 rtl/serial_sub_ctrl_fs.sv | 16 +
 rtl/serial_sub_ctrl.sv | 107 ++++++++++
 4 files changed

// File: rtl/serial_sub_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor controller.
// Holds the FSM state encoding, the default operand width and the
// bit-counter width helper used by the controller.
package serial_sub_ctrl_pkg;

  localparam int DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Counter must hold 0..WIDTH-1; a 1-bit operand still needs a 1-bit counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// Request/result bundle between a datapath and the serial subtractor.
// master: drives start/a/b/bin, observes busy/done/diff/bout.
// slave : the controller side of the same signals.
interface serial_sub_ctrl_if
  import serial_sub_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );

endinterface

// File: rtl/serial_sub_ctrl_fs.sv
// One-bit full subtractor cell: diff = a - b - c, brw = borrow out.
// Ports: a (minuend bit), b (subtrahend bit), c (borrow in),
//        diff (difference bit), brw (borrow out). Purely combinational.
module fs (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic diff,
  output logic brw
);

  assign diff = a ^ b ^ c;
  // Borrow when the subtrahend side exceeds the minuend bit.
  assign brw  = (~a & (b | c)) | (b & c);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor controller: {bout, diff} = a - b - bin, LSB first.
// Ports: clk, rst (sync, active-high), bus (slave side: start/a/b/bin in,
//        busy/done/diff/bout out, all outputs registered). Latency WIDTH cycles.
module serial_sub_ctrl
  import serial_sub_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  serial_sub_ctrl_if.slave   bus
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_sd;
  logic             r_br;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;
  logic             r_busy;
  logic             r_done;

  logic             w_cell_d;
  logic             w_cell_b;
  logic             w_last;
  logic [WIDTH-1:0] w_sd_next;

  fs u_cell (
    .a    (r_sa[0]),
    .b    (r_sb[0]),
    .c    (r_br),
    .diff (w_cell_d),
    .brw  (w_cell_b)
  );

  assign w_last = (r_cnt == LAST_CNT);

  // Result assembles MSB-first into sd; written this way so WIDTH=1 needs no slice.
  always_comb begin
    w_sd_next            = r_sd >> 1;
    w_sd_next[WIDTH-1]   = w_cell_d;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.start) w_next = ST_SHIFT;
      ST_SHIFT: if (w_last)    w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_sa    <= '0;
      r_sb    <= '0;
      r_sd    <= '0;
      r_br    <= 1'b0;
      r_diff  <= '0;
      r_bout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      // busy/done decoded from the next state so they are flops, not logic on r_state.
      r_busy  <= (w_next != ST_IDLE);
      r_done  <= (w_next == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_sa  <= bus.a;
            r_sb  <= bus.b;
            r_br  <= bus.bin;
            r_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_sd  <= w_sd_next;
          r_br  <= w_cell_b;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_diff <= w_sd_next;
            r_bout <= w_cell_b;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.diff = r_diff;
  assign bus.bout = r_bout;

endmodule
